regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Sole owner of the register file's write side. It arbitrates three writers (ALU result, AGU address update, memory byte loads) onto the file's write strobes, so at most one strobe is active per cycle.
- It sequences two-byte memory loads: upper byte, then lower byte.
- While a split load is open, it locks the destination register and exports that lock for hazard checks.

Parameters:
- AW, 4, register address width (16 registers)
- DW, 16, register data width
- BW, 8, memory byte width (DW = 2*BW)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_req  in  1  ALU write request, held until alu_gnt
- alu_addr  in  AW  ALU destination
- alu_data  in  DW  ALU result
- alu_gnt  out  1  combinational grant, same cycle
- agu_req  in  1  AGU write request, held until agu_gnt
- agu_addr  in  AW  AGU destination
- agu_data  in  DW  AGU value
- agu_gnt  out  1  combinational grant
- mem_valid  in  1  memory byte present
- mem_upper  in  1  1 = upper byte, 0 = lower byte
- mem_addr  in  AW  load destination
- mem_byte  in  BW  load byte
- mem_ready  out  1  combinational accept; transfer when mem_valid & mem_ready
- mem_abort  in  1  cancel an open split load
- rf_writeu  out  1  register-file upper-byte strobe
- rf_writel  out  1  register-file lower-byte strobe
- rf_write4  out  1  register-file full-word strobe
- rf_addr3  out  AW  byte-path address
- rf_bus3  out  DW  byte-path data, byte replicated in both halves
- rf_addr4  out  AW  word-path address
- rf_bus4  out  DW  word-path data
- lock_busy  out  1  split load open
- lock_addr  out  AW  locked register
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, any state): FSM = IDLE; all strobes, lock_busy and proto_err = 0; all addresses and buses = 0; round-robin pointer points to ALU.
- Latency: grants/ready are combinational in cycle N. Accepted writes are registered, so rf_* are valid during cycle N+1 and the register updates at the end of N+1. Strobes are single-cycle pulses.
- One strobe per cycle. Memory has priority: when mem_ready & mem_valid, alu_gnt = agu_gnt = 0.
- ALU vs AGU: round-robin. The pointer toggles to the other requester after each grant. A lone requester is granted every free cycle.
- FSM states: IDLE, LOCKED.
- IDLE:
  - mem_ready = 1.
  - Upper byte accepted: rf_writeu, rf_addr3 = mem_addr; lock_addr <= mem_addr; go to LOCKED.
  - Lower byte accepted: standalone rf_writel; stay in IDLE.
- LOCKED:
  - mem_ready = 1 only for a lower byte with mem_addr == lock_addr. That byte issues rf_writel and returns to IDLE.
  - Upper byte or mismatched address while LOCKED: mem_ready = 0, proto_err <= 1, FSM stays LOCKED.
  - ALU/AGU requests whose addr == lock_addr are not granted. The other requester may be granted, and the pointer is not consumed.
- mem_abort in LOCKED: return to IDLE with no write; it wins over a same-cycle lower byte, which is not accepted (mem_ready = 0). mem_abort in IDLE is ignored.
- lock_busy = (state == LOCKED); lock_addr is valid only while lock_busy = 1.
- proto_err is cleared only by reset.

Test Plan:
- alu_req, addr 3, data 0x1234, alone → alu_gnt in cycle N; rf_write4 = 1, rf_addr4 = 3, rf_bus4 = 0x1234 in N+1; no other strobe.
- alu_req and agu_req held 4 cycles → grants alternate ALU, AGU, ALU, AGU starting from ALU after reset; exactly one rf_write4 per cycle.
- Upper 0xAB to r5, then lower 0xCD to r5 → rf_writeu then rf_writel, rf_addr3 = 5; lock_busy high between; FSM back in IDLE.
- While locked on r5: alu_req r5 and agu_req r6 → agu_gnt only; alu_gnt follows the cycle after the lower byte completes.
- While locked on r5: upper byte to r7 → mem_ready = 0, proto_err = 1; then mem_abort → IDLE with no rf_writel.
- Assert rst_n = 0 in LOCKED mid-transfer → all outputs 0 asynchronously; after release, a lower byte is accepted as a standalone write.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-side arbiter for the register file: ALU/AGU round-robin word writes
// plus memory byte loads, with destination locking across split loads.
module regfile_write_arbiter #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_req,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_gnt,
    input  logic          agu_req,
    input  logic [AW-1:0] agu_addr,
    input  logic [DW-1:0] agu_data,
    output logic          agu_gnt,
    input  logic          mem_valid,
    input  logic          mem_upper,
    input  logic [AW-1:0] mem_addr,
    input  logic [BW-1:0] mem_byte,
    output logic          mem_ready,
    input  logic          mem_abort,
    output logic          rf_writeu,
    output logic          rf_writel,
    output logic          rf_write4,
    output logic [AW-1:0] rf_addr3,
    output logic [DW-1:0] rf_bus3,
    output logic [AW-1:0] rf_addr4,
    output logic [DW-1:0] rf_bus4,
    output logic          lock_busy,
    output logic [AW-1:0] lock_addr,
    output logic          proto_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t state, next_state;
    logic   rr_agu;        // 1: AGU wins the next ALU/AGU contention
    logic   rr_next;
    logic   alu_ok, agu_ok;
    logic   mem_xfer;
    logic   set_err;

    // Next state, memory handshake, grants and pointer update
    always_comb begin
        next_state = state;
        mem_ready  = 1'b0;
        alu_gnt    = 1'b0;
        agu_gnt    = 1'b0;
        set_err    = 1'b0;
        rr_next    = rr_agu;
        alu_ok     = alu_req;
        agu_ok     = agu_req;

        case (state)
            IDLE: begin
                mem_ready = 1'b1;
                if (mem_valid && mem_upper)
                    next_state = LOCKED;
            end
            LOCKED: begin
                alu_ok = alu_req && (alu_addr != lock_addr);
                agu_ok = agu_req && (agu_addr != lock_addr);
                if (mem_abort) begin
                    next_state = IDLE;
                end else if (mem_valid && !mem_upper && (mem_addr == lock_addr)) begin
                    mem_ready  = 1'b1;
                    next_state = IDLE;
                end
                if (mem_valid && (mem_upper || (mem_addr != lock_addr)))
                    set_err = 1'b1;
            end
            default: next_state = IDLE;
        endcase

        mem_xfer = mem_valid && mem_ready;

        // A requester blocked by the lock does not consume its turn
        if (!mem_xfer) begin
            if (alu_ok && agu_ok) begin
                alu_gnt = !rr_agu;
                agu_gnt = rr_agu;
                rr_next = !rr_agu;
            end else if (alu_ok) begin
                alu_gnt = 1'b1;
                rr_next = agu_req ? rr_agu : 1'b1;
            end else if (agu_ok) begin
                agu_gnt = 1'b1;
                rr_next = alu_req ? rr_agu : 1'b0;
            end
        end
    end

    assign lock_busy = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_agu    <= 1'b0;
            lock_addr <= '0;
            proto_err <= 1'b0;
            rf_writeu <= 1'b0;
            rf_writel <= 1'b0;
            rf_write4 <= 1'b0;
            rf_addr3  <= '0;
            rf_bus3   <= '0;
            rf_addr4  <= '0;
            rf_bus4   <= '0;
        end else begin
            state     <= next_state;
            rr_agu    <= rr_next;
            rf_writeu <= mem_xfer && mem_upper;
            rf_writel <= mem_xfer && !mem_upper;
            rf_write4 <= alu_gnt || agu_gnt;
            if (set_err)
                proto_err <= 1'b1;
            if (mem_xfer) begin
                rf_addr3 <= mem_addr;
                rf_bus3  <= DW'({mem_byte, mem_byte});
            end
            if (mem_xfer && mem_upper)
                lock_addr <= mem_addr;
            if (alu_gnt) begin
                rf_addr4 <= alu_addr;
                rf_bus4  <= alu_data;
            end else if (agu_gnt) begin
                rf_addr4 <= agu_addr;
                rf_bus4  <= agu_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: expected register-file writes are queued by the stimulus and
// popped by a monitor whenever a write strobe appears.
module tb_regfile_write_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    localparam logic [1:0] K_WORD  = 2'd0;
    localparam logic [1:0] K_UPPER = 2'd1;
    localparam logic [1:0] K_LOWER = 2'd2;

    typedef struct {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_req, agu_req, mem_valid, mem_upper, mem_abort;
    logic [AW-1:0] alu_addr, agu_addr, mem_addr;
    logic [DW-1:0] alu_data, agu_data;
    logic [BW-1:0] mem_byte;
    logic          alu_gnt, agu_gnt, mem_ready;
    logic          rf_writeu, rf_writel, rf_write4, lock_busy, proto_err;
    logic [AW-1:0] rf_addr3, rf_addr4, lock_addr;
    logic [DW-1:0] rf_bus3, rf_bus4;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];

    regfile_write_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
        .agu_req(agu_req), .agu_addr(agu_addr), .agu_data(agu_data), .agu_gnt(agu_gnt),
        .mem_valid(mem_valid), .mem_upper(mem_upper), .mem_addr(mem_addr),
        .mem_byte(mem_byte), .mem_ready(mem_ready), .mem_abort(mem_abort),
        .rf_writeu(rf_writeu), .rf_writel(rf_writel), .rf_write4(rf_write4),
        .rf_addr3(rf_addr3), .rf_bus3(rf_bus3), .rf_addr4(rf_addr4), .rf_bus4(rf_bus4),
        .lock_busy(lock_busy), .lock_addr(lock_addr), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t w;
        w.kind = kind;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_req = 0; agu_req = 0; mem_valid = 0; mem_upper = 0; mem_abort = 0;
        alu_addr = '0; agu_addr = '0; mem_addr = '0;
        alu_data = '0; agu_data = '0; mem_byte = '0;
    endtask

    task automatic do_reset();
        sample();
        rst_n = 0;
        #2;
        sample();
        rst_n = 1;
        tick();
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n) begin
            int  n;
            wr_t w;
            n = int'(rf_writeu) + int'(rf_writel) + int'(rf_write4);
            if (n > 1) begin
                checks++;
                failures++;
                $display("FAIL strobe_count: got %0d strobes expected 1 at %0t", n, $time);
            end else if (n == 1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got u=%0b l=%0b w=%0b expected none at %0t",
                             rf_writeu, rf_writel, rf_write4, $time);
                end else begin
                    w = exp_q.pop_front();
                    if (w.kind == K_WORD) begin
                        check("sb_word_strobe", 32'(rf_write4), 32'd1);
                        check("sb_word_addr", 32'(rf_addr4), 32'(w.addr));
                        check("sb_word_data", 32'(rf_bus4), 32'(w.data));
                    end else begin
                        check("sb_byte_upper", 32'(rf_writeu), 32'(w.kind == K_UPPER));
                        check("sb_byte_addr", 32'(rf_addr3), 32'(w.addr));
                        check("sb_byte_data", 32'(rf_bus3), 32'(w.data));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        #12;
        check("reset_outputs",
              32'({rf_writeu, rf_writel, rf_write4, lock_busy, proto_err, rf_addr3, rf_addr4, lock_addr}),
              32'd0);
        check("reset_bus3", 32'(rf_bus3), 32'd0);
        check("reset_bus4", 32'(rf_bus4), 32'd0);
        sample();
        rst_n = 1;
        tick();

        // Lone ALU write
        alu_req = 1; alu_addr = 4'd3; alu_data = 16'h1234;
        sample();
        check("alu_alone_gnt", 32'({alu_gnt, agu_gnt}), 32'b10);
        push(K_WORD, 4'd3, 16'h1234);
        tick();
        idle_inputs();
        tick();

        // Round-robin from a fresh reset
        do_reset();
        alu_req = 1; alu_addr = 4'd1; alu_data = 16'h1111;
        agu_req = 1; agu_addr = 4'd2; agu_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (i % 2 == 0) begin
                check("rr_gnt_alu", 32'({alu_gnt, agu_gnt}), 32'b10);
                push(K_WORD, 4'd1, 16'h1111);
            end else begin
                check("rr_gnt_agu", 32'({alu_gnt, agu_gnt}), 32'b01);
                push(K_WORD, 4'd2, 16'h2222);
            end
            tick();
        end
        idle_inputs();
        tick();
        do_reset();

        // Split load to r5 with a locked ALU request
        mem_valid = 1; mem_upper = 1; mem_addr = 4'd5; mem_byte = 8'hAB;
        sample();
        check("upper_ready", 32'(mem_ready), 32'd1);
        push(K_UPPER, 4'd5, 16'hABAB);
        tick();
        idle_inputs();
        alu_req = 1; alu_addr = 4'd5; alu_data = 16'h5555;
        agu_req = 1; agu_addr = 4'd6; agu_data = 16'h6666;
        sample();
        check("locked_busy", 32'({lock_busy, lock_addr}), 32'({1'b1, 4'd5}));
        check("locked_gnt", 32'({alu_gnt, agu_gnt}), 32'b01);
        push(K_WORD, 4'd6, 16'h6666);
        tick();
        agu_req = 0;
        mem_valid = 1; mem_upper = 0; mem_addr = 4'd5; mem_byte = 8'hCD;
        sample();
        check("lower_ready", 32'(mem_ready), 32'd1);
        check("lower_alu_blocked", 32'(alu_gnt), 32'd0);
        push(K_LOWER, 4'd5, 16'hCDCD);
        tick();
        mem_valid = 0;
        sample();
        check("unlocked_busy", 32'(lock_busy), 32'd0);
        check("unlocked_alu_gnt", 32'({alu_gnt, agu_gnt}), 32'b10);
        push(K_WORD, 4'd5, 16'h5555);
        tick();
        idle_inputs();
        tick();

        // Protocol error then abort
        mem_valid = 1; mem_upper = 1; mem_addr = 4'd5; mem_byte = 8'h12;
        sample();
        push(K_UPPER, 4'd5, 16'h1212);
        tick();
        mem_addr = 4'd7; mem_byte = 8'h34;
        sample();
        check("err_ready", 32'(mem_ready), 32'd0);
        tick();
        mem_upper = 0; mem_addr = 4'd5; mem_abort = 1;
        sample();
        check("err_sticky", 32'({proto_err, lock_busy}), 32'b11);
        check("abort_ready", 32'(mem_ready), 32'd0);
        tick();
        idle_inputs();
        sample();
        check("abort_idle", 32'({lock_busy, proto_err}), 32'b01);
        tick();

        // Reset in the middle of a split load
        mem_valid = 1; mem_upper = 1; mem_addr = 4'd9; mem_byte = 8'h55;
        sample();
        push(K_UPPER, 4'd9, 16'h5555);
        tick();
        idle_inputs();
        tick();
        #1;
        rst_n = 0;
        #1;
        check("async_reset_outputs",
              32'({rf_writeu, rf_writel, rf_write4, lock_busy, proto_err, rf_addr3, rf_addr4, lock_addr}),
              32'd0);
        check("async_reset_buses", 32'({rf_bus3, rf_bus4}), 32'd0);
        sample();
        rst_n = 1;
        tick();
        mem_valid = 1; mem_upper = 0; mem_addr = 4'd9; mem_byte = 8'h77;
        sample();
        check("post_reset_ready", 32'(mem_ready), 32'd1);
        push(K_LOWER, 4'd9, 16'h7777);
        tick();
        idle_inputs();
        sample();
        check("post_reset_unlocked", 32'(lock_busy), 32'd0);
        tick();
        sample();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
